// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, slave FSM states and the byte-lane enable helper
// for the on-chip SRAM responder.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8    = 3'd0;
  localparam logic [2:0] HSIZE_B16   = 3'd1;
  localparam logic [2:0] HSIZE_B32   = 3'd2;
  localparam logic [2:0] HSIZE_B64   = 3'd3;
  localparam logic [2:0] HSIZE_B128  = 3'd4;
  localparam logic [2:0] HSIZE_B256  = 3'd5;
  localparam logic [2:0] HSIZE_B512  = 3'd6;
  localparam logic [2:0] HSIZE_B1024 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte enables for a 64-bit lane group; narrower buses use the low bits.
  function automatic logic [7:0] gen_be(input logic [2:0] hsize,
                                        input logic [2:0] haddr_lsbs);
    case (hsize)
      HSIZE_B8:  gen_be = 8'h01 << haddr_lsbs;
      HSIZE_B16: gen_be = 8'h03 << {haddr_lsbs[2:1], 1'b0};
      HSIZE_B32: gen_be = 8'h0F << {haddr_lsbs[2], 2'b00};
      default:   gen_be = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ahb3lite_slave_ram.sv
// Word-organised RAM with byte-write enables and a registered read port that
// forwards bytes being written on the same edge to the same word.
module ahb3lite_slave_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rdata_q;

  always_comb begin
    rd_word = mem[raddr_i];
    for (int b = 0; b < NB; b++) begin
      if (we_i && (waddr_i == raddr_i) && be_i[b]) rd_word[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  // NOTE: the storage array has no reset; clearing it would turn the RAM into flops.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i && be_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= rd_word;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: bus FSM with optional wait states and a two-cycle
// ERROR response in front of a byte-writable word RAM.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB         = HDATA_SIZE / 8;
  localparam int BYTE_IDX_W = $clog2(NB);
  localparam int AW         = $clog2(DEPTH);
  localparam int LA_W       = BYTE_IDX_W + AW;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            dphase_q, dphase_d;
  logic            write_q;
  logic [2:0]      size_q;
  logic [LA_W-1:0] addr_q;

  logic                  accept, xfer_err, out_of_range, size_err, misaligned;
  logic [HADDR_SIZE-1:0] align_mask;
  logic                  ram_we, ram_re, rd_now, rd_late;
  logic [AW-1:0]         ram_raddr;
  logic [NB-1:0]         ram_be;
  logic                  unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

  assign accept       = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign out_of_range = 32'(HADDR >> BYTE_IDX_W) >= 32'(DEPTH);
  assign size_err     = HSIZE > 3'(BYTE_IDX_W);
  assign align_mask   = (HADDR_SIZE'(1) << HSIZE) - HADDR_SIZE'(1);
  assign misaligned   = |(HADDR & align_mask);
  assign xfer_err     = out_of_range || size_err || misaligned;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = ST_IDLE;
    cnt_d     = cnt_q;
    dphase_d  = dphase_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q != 4'd0) begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
        dphase_d = 1'b0;
        if (accept) begin
          dphase_d = !xfer_err;
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= HSIZE_B8;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      if (accept) begin
        write_q <= HWRITE;
        size_q  <= HSIZE;
        addr_q  <= HADDR[LA_W-1:0];
      end
    end
  end

  // The OKAY data phase completes in the IDLE cycle; writes commit at its end.
  assign ram_we = (state_q == ST_IDLE) && dphase_q && write_q && !HRESET;
  assign ram_be = NB'(gen_be(size_q, 3'(addr_q[BYTE_IDX_W-1:0])));

  assign rd_now    = accept && !xfer_err && !HWRITE && (WAIT_STATES == 0);
  assign rd_late   = (state_q == ST_WAIT) && (cnt_q == 4'd0) && dphase_q && !write_q;
  assign ram_re    = !HRESET && (rd_now || rd_late);
  assign ram_raddr = rd_late ? addr_q[BYTE_IDX_W +: AW] : HADDR[BYTE_IDX_W +: AW];

  ahb3lite_slave_ram #(
    .DEPTH (DEPTH),
    .DW    (HDATA_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .we_i    (ram_we),
    .waddr_i (addr_q[BYTE_IDX_W +: AW]),
    .be_i    (ram_be),
    .wdata_i (HWDATA),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (HRDATA)
  );

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: a zero-wait and a three-wait instance share the address/data
// buses, each with its own HSEL and HREADYOUT->HREADY loop.
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sel0, sel3;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rdata0), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel3), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rdata3), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(rdy3), .HREADYOUT(rdy3), .HRESP(resp3)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [15:0] a, input logic wr,
                       input logic [2:0] sz);
    HTRANS = tr;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = sz;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; sel0 = 1'b0; sel3 = 1'b0; HWDATA = '0; HBURST = 3'd0;
    HPROT = 4'd0; HMASTLOCK = 1'b0;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step(); step();
    HRESET = 1'b0;
    checks++; if ({rdy0, resp0} !== 2'b10) begin failures++; $display("FAIL reset_dut0_rdy_resp got=%b exp=10", {rdy0, resp0}); end
    checks++; if ({rdy3, resp3} !== 2'b10) begin failures++; $display("FAIL reset_dut3_rdy_resp got=%b exp=10", {rdy3, resp3}); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_dut0_hrdata got=%h exp=00000000", rdata0); end
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL reset_dut3_hrdata got=%h exp=00000000", rdata3); end
  endtask

  task automatic test_write_read_bypass();
    sel0 = 1'b1;
    drive(HTRANS_NONSEQ, 16'h0010, 1'b1, HSIZE_B32);
    step();
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL bypass_rdy_wr got=%b exp=1", rdy0); end
    HWDATA = 32'hDEADBEEF;
    drive(HTRANS_NONSEQ, 16'h0010, 1'b0, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b10) begin failures++; $display("FAIL bypass_rdy_resp got=%b exp=10", {rdy0, resp0}); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rdata got=%h exp=deadbeef", rdata0); end
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL bypass_rdy_idle got=%b exp=1", rdy0); end
  endtask

  task automatic test_byte_lanes();
    drive(HTRANS_NONSEQ, 16'h0020, 1'b1, HSIZE_B32);
    step();
    HWDATA = 32'h11223344;
    drive(HTRANS_NONSEQ, 16'h0021, 1'b1, HSIZE_B8);
    step();
    HWDATA = 32'hAABBCCDD;
    drive(HTRANS_NONSEQ, 16'h0020, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h1122CC44) begin failures++; $display("FAIL byte_write_rdata got=%h exp=1122cc44", rdata0); end
    drive(HTRANS_NONSEQ, 16'h0022, 1'b1, HSIZE_B16);
    step();
    HWDATA = 32'h55667788;
    drive(HTRANS_NONSEQ, 16'h0020, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h5566CC44) begin failures++; $display("FAIL half_write_rdata got=%h exp=5566cc44", rdata0); end
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    drive(HTRANS_NONSEQ, 16'h0020, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h5566CC44) begin failures++; $display("FAIL lane_reread got=%h exp=5566cc44", rdata0); end
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
  endtask

  task automatic test_wait_states();
    sel0 = 1'b0; sel3 = 1'b1;
    drive(HTRANS_NONSEQ, 16'h0040, 1'b1, HSIZE_B32);
    step();
    HWDATA = 32'hCAFEF00D;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    for (int i = 1; i <= 3; i++) begin
      checks++; if ({rdy3, resp3} !== 2'b00) begin failures++; $display("FAIL ws_write_cycle%0d got=%b exp=00", i, {rdy3, resp3}); end
      step();
    end
    checks++; if ({rdy3, resp3} !== 2'b10) begin failures++; $display("FAIL ws_write_done got=%b exp=10", {rdy3, resp3}); end
    drive(HTRANS_NONSEQ, 16'h0040, 1'b0, HSIZE_B32);
    step();
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    for (int i = 1; i <= 3; i++) begin
      checks++; if ({rdy3, resp3} !== 2'b00) begin failures++; $display("FAIL ws_read_cycle%0d got=%b exp=00", i, {rdy3, resp3}); end
      checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL ws_read_hold%0d got=%h exp=00000000", i, rdata3); end
      step();
    end
    checks++; if ({rdy3, resp3} !== 2'b10) begin failures++; $display("FAIL ws_read_done got=%b exp=10", {rdy3, resp3}); end
    checks++; if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL ws_read_data got=%h exp=cafef00d", rdata3); end
    sel3 = 1'b0;
    step();
  endtask

  task automatic test_error();
    sel0 = 1'b1;
    drive(HTRANS_NONSEQ, 16'h0000, 1'b1, HSIZE_B32);
    step();
    HWDATA = 32'h0BADC0DE;
    drive(HTRANS_NONSEQ, 16'h0FFC, 1'b1, HSIZE_B32);
    step();
    HWDATA = 32'h600DF00D;
    drive(HTRANS_NONSEQ, 16'h1000, 1'b1, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b01) begin failures++; $display("FAIL range_err1 got=%b exp=01", {rdy0, resp0}); end
    HWDATA = 32'h12345678;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b11) begin failures++; $display("FAIL range_err2 got=%b exp=11", {rdy0, resp0}); end
    drive(HTRANS_NONSEQ, 16'h0FFC, 1'b0, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b10) begin failures++; $display("FAIL range_after got=%b exp=10", {rdy0, resp0}); end
    checks++; if (rdata0 !== 32'h600DF00D) begin failures++; $display("FAIL range_last_word got=%h exp=600df00d", rdata0); end
    drive(HTRANS_NONSEQ, 16'h0000, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h0BADC0DE) begin failures++; $display("FAIL range_alias_word got=%h exp=0badc0de", rdata0); end
    drive(HTRANS_NONSEQ, 16'h0003, 1'b1, HSIZE_B16);
    step();
    checks++; if ({rdy0, resp0} !== 2'b01) begin failures++; $display("FAIL align_err1 got=%b exp=01", {rdy0, resp0}); end
    HWDATA = 32'hFFFFFFFF;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b11) begin failures++; $display("FAIL align_err2 got=%b exp=11", {rdy0, resp0}); end
    drive(HTRANS_NONSEQ, 16'h0000, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h0BADC0DE) begin failures++; $display("FAIL align_ram_kept got=%h exp=0badc0de", rdata0); end
    drive(HTRANS_NONSEQ, 16'h0000, 1'b0, HSIZE_B64);
    step();
    checks++; if ({rdy0, resp0} !== 2'b01) begin failures++; $display("FAIL size_err1 got=%b exp=01", {rdy0, resp0}); end
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b11) begin failures++; $display("FAIL size_err2 got=%b exp=11", {rdy0, resp0}); end
    checks++; if (rdata0 !== 32'h0BADC0DE) begin failures++; $display("FAIL size_err_hold got=%h exp=0badc0de", rdata0); end
    step();
  endtask

  task automatic test_idle_busy();
    HBURST = 3'd1;
    drive(HTRANS_NONSEQ, 16'h0030, 1'b1, HSIZE_B32);
    step();
    HWDATA = 32'h01010101;
    drive(HTRANS_BUSY, 16'h0034, 1'b1, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b10) begin failures++; $display("FAIL busy_okay got=%b exp=10", {rdy0, resp0}); end
    HWDATA = 32'hFFFFFFFF;
    drive(HTRANS_SEQ, 16'h0034, 1'b1, HSIZE_B32);
    step();
    HWDATA = 32'h02020202;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    sel0 = 1'b0;
    drive(HTRANS_NONSEQ, 16'h0030, 1'b1, HSIZE_B32);
    step();
    checks++; if ({rdy0, resp0} !== 2'b10) begin failures++; $display("FAIL unsel_okay got=%b exp=10", {rdy0, resp0}); end
    HWDATA = 32'hEEEEEEEE;
    drive(HTRANS_NONSEQ, 16'h0034, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h0BADC0DE) begin failures++; $display("FAIL unsel_hold got=%h exp=0badc0de", rdata0); end
    sel0 = 1'b1;
    drive(HTRANS_NONSEQ, 16'h0030, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h01010101) begin failures++; $display("FAIL burst_beat0 got=%h exp=01010101", rdata0); end
    drive(HTRANS_NONSEQ, 16'h0034, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdata0 !== 32'h02020202) begin failures++; $display("FAIL burst_beat1 got=%h exp=02020202", rdata0); end
    sel0 = 1'b0;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
  endtask

  task automatic test_reset_in_wait();
    sel3 = 1'b1;
    drive(HTRANS_NONSEQ, 16'h0040, 1'b1, HSIZE_B32);
    step();
    sel3 = 1'b0;
    HWDATA = 32'h55555555;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step();
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL rst_wait_pre got=%b exp=0", rdy3); end
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    checks++; if ({rdy3, resp3} !== 2'b10) begin failures++; $display("FAIL rst_wait_okay got=%b exp=10", {rdy3, resp3}); end
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL rst_wait_hrdata got=%h exp=00000000", rdata3); end
    step();
    sel3 = 1'b1;
    drive(HTRANS_NONSEQ, 16'h0040, 1'b0, HSIZE_B32);
    step();
    sel3 = 1'b0;
    drive(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_B32);
    step(); step(); step();
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL rst_read_rdy got=%b exp=1", rdy3); end
    checks++; if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_write_discarded got=%h exp=cafef00d", rdata3); end
  endtask

  initial begin
    test_reset();
    test_write_read_bypass();
    test_byte_lanes();
    test_wait_states();
    test_error();
    test_idle_busy();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
